// File: rtl/uart_pkg.sv
// Shared launch-FSM encoding and default widths for the UART TX FIFO controller.
package uart_pkg;

    localparam int DEF_DATA  = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO storage with wrapping pointers and an occupancy counter.
// A write is accepted when not full, or when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DATA  = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [DATA-1:0] wr_data,
    input  logic            rd_en,
    output logic [DATA-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    logic [DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_ok, rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);

    // Occupancy only moves when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointers and count; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffers producer bytes and hands them one at a time to the UART transmitter
// through a start/busy handshake, with a watchdog on the busy response.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA       = DEF_DATA,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LAUNCH_TMO = 16,
    localparam int CW        = $clog2(DEPTH) + 1,
    localparam int TW        = $clog2(LAUNCH_TMO + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [DATA-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            tx_start,
    output logic [DATA-1:0] tx_data,
    input  logic            tx_busy,
    output logic            launch_err
);

    tx_state_e       state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            start_q, start_d;
    logic [DATA-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            pop;
    logic [DATA-1:0] head;

    sync_fifo #(.DATA(DATA), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign tx_start   = start_q;
    assign tx_data    = data_q;
    assign launch_err = err_q;
    assign overflow   = ovf_q;

    // Launch FSM: pop only from IDLE, so a BUSY->IDLE edge never launches.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        start_d = start_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                    start_d = 1'b1;
                    data_d  = head;
                    tmo_d   = '0;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    state_d = BUSY;
                    start_d = 1'b0;
                end else if (tmo_q == TW'(LAUNCH_TMO - 1)) begin
                    // Transmitter never answered: give up on this byte.
                    state_d = IDLE;
                    start_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            BUSY: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
        ovf_d = wr_en && full && !pop;
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a simple transmitter responder.
module tb_uart_tx_fifo_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_start, launch_err;
    logic [3:0] count;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic       auto_en    = 1'b0;
    logic       man_busy   = 1'b0;
    logic       model_busy = 1'b0;
    int         bcnt       = 0;
    logic [7:0] cap [0:255];
    int         cap_n      = 0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign tx_busy = auto_en ? model_busy : man_busy;

    uart_tx_fifo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .launch_err (launch_err)
    );

    // Transmitter stand-in: accepts a launch, stays busy a few cycles, logs the byte.
    always @(posedge clk) begin
        if (auto_en && tx_start && !model_busy) begin
            model_busy <= 1'b1;
            bcnt       <= 4;
            cap[cap_n[7:0]] <= tx_data;
            cap_n      <= cap_n + 1;
        end else if (model_busy) begin
            if (bcnt == 0) model_busy <= 1'b0;
            else           bcnt <= bcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [7:0] b0, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = b0 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Bounded wait for FIFO empty and FSM settled in IDLE with transmitter idle.
    task automatic wait_drain(input string tag);
        int k = 0;
        while (!(empty && dut.state_q == IDLE && !tx_busy && !tx_start) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 2000), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input int base, input logic [7:0] exp [],
                           input int n);
        chk({tag, "_n"}, 32'(cap_n - base), 32'(n));
        for (int i = 0; i < n; i++)
            chk(tag, {24'd0, cap[8'(base + i)]}, {24'd0, exp[i]});
    endtask

    initial begin
        int hc;
        int base;
        int k;
        logic [7:0] exp [];

        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        #2;
        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(launch_err), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_start", 32'(tx_start), 32'd0);

        // Latency and launch timeout with tx_busy tied low
        wr_en = 1'b1; wr_data = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat_c1_start", 32'(tx_start), 32'd0);
        chk("lat_c1_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("lat_c2_start", 32'(tx_start), 32'd1);
        chk("lat_c2_data", 32'(tx_data), 32'h42);
        chk("lat_c2_count", 32'(count), 32'd0);
        hc = 0;
        while (tx_start && hc < 40) begin
            hc++;
            @(negedge clk);
        end
        chk("tmo_high_cycles", 32'(hc), 32'd16);
        chk("tmo_err", 32'(launch_err), 32'd1);
        chk("tmo_state", 32'(dut.state_q), 32'(IDLE));
        chk("tmo_count", 32'(count), 32'd0);
        chk("tmo_data_hold", 32'(tx_data), 32'h42);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(launch_err), 32'd1);
        reset = 1'b0;
        #1;
        chk("err_cleared", 32'(launch_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Overflow: 9 writes while transmitter busy
        man_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            @(negedge clk);
            if (i == 7) begin
                chk("ovf_count8", 32'(count), 32'd8);
                chk("ovf_full", 32'(full), 32'd1);
                chk("ovf_none_yet", 32'(overflow), 32'd0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count_hold", 32'(count), 32'd8);
        @(negedge clk);
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        base = cap_n;
        auto_en = 1'b1;
        wait_drain("ovf_drain");
        exp = new[8];
        foreach (exp[i]) exp[i] = 8'(i + 1);
        chk_seq("ovf_order", base, exp, 8);

        // Write into a full FIFO in the pop cycle
        auto_en = 1'b0; man_busy = 1'b1;
        wr_burst(8'h11, 8);
        chk("wp_full", 32'(full), 32'd1);
        man_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h7E;
        @(negedge clk);
        wr_en = 1'b0;
        auto_en = 1'b1;
        base = cap_n;
        chk("wp_count", 32'(count), 32'd8);
        chk("wp_ovf", 32'(overflow), 32'd0);
        chk("wp_start", 32'(tx_start), 32'd1);
        chk("wp_data", 32'(tx_data), 32'h11);
        wait_drain("wp_drain");
        exp = new[9];
        for (int i = 0; i < 8; i++) exp[i] = 8'h11 + 8'(i);
        exp[8] = 8'h7E;
        chk_seq("wp_order", base, exp, 9);

        // Back-to-back frames through the responder
        base = cap_n;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hD3;
        @(negedge clk); wr_data = 8'hA5;
        @(negedge clk); wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'h55;
        @(negedge clk); wr_en = 1'b0;
        wait_drain("b2b_drain");
        exp = new[4];
        exp[0] = 8'hD3; exp[1] = 8'hA5; exp[2] = 8'h3C; exp[3] = 8'h55;
        chk_seq("b2b_order", base, exp, 4);

        // Reset mid-frame with 3 bytes queued
        wr_burst(8'h60, 4);
        k = 0;
        while (!(model_busy && count == 4'd3) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mrst_setup", 32'(k < 100), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mrst_start", 32'(tx_start), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        hc = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) hc++;
        end
        chk("mrst_no_launch", 32'(hc), 32'd0);

        // Pointer wrap: fill/drain twice
        auto_en = 1'b0; man_busy = 1'b1;
        wr_burst(8'hA0, 8);
        chk("wrap1_full", 32'(full), 32'd1);
        base = cap_n;
        auto_en = 1'b1;
        wait_drain("wrap1_drain");
        exp = new[8];
        foreach (exp[i]) exp[i] = 8'hA0 + 8'(i);
        chk_seq("wrap1_order", base, exp, 8);
        auto_en = 1'b0; man_busy = 1'b1;
        wr_burst(8'hB0, 8);
        chk("wrap2_full", 32'(full), 32'd1);
        base = cap_n;
        auto_en = 1'b1;
        wait_drain("wrap2_drain");
        foreach (exp[i]) exp[i] = 8'hB0 + 8'(i);
        chk_seq("wrap2_order", base, exp, 8);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA, default 8, meaning the byte width passed to the UART transmitter.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the FIFO entry count; power of 2, at least 2.
REQ-003 SHALL have parameter LAUNCH_TMO, default 16, meaning the cycles allowed for tx_busy to rise after tx_start.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all flops on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port wr_en, input, 1 bit: the producer write strobe.
REQ-007 SHALL have port wr_data, input, DATA bits: the byte to enqueue.
REQ-008 SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-009 SHALL have port empty, output, 1 bit: the FIFO holds 0 entries.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: a one-cycle pulse when a write is dropped.
REQ-012 SHALL have port tx_start, output, 1 bit: the launch request to uart_protocol.
REQ-013 SHALL have port tx_data, output, DATA bits: the byte presented to uart_protocol.
REQ-014 SHALL have port tx_busy, input, 1 bit: the busy flag from uart_protocol.
REQ-015 SHALL have port launch_err, output, 1 bit: sticky; set when the launch timeout expires.

Function
REQ-016 SHALL implement a circular FIFO with rd_ptr and wr_ptr of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when wr_en=1 and either full=0 or a pop occurs in the same cycle; the entry is visible in count on the next cycle.
REQ-018 A write with wr_en=1, full=1 and no same-cycle pop SHALL be dropped, leave pointers and count unchanged, and pulse overflow for 1 cycle.
REQ-019 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-020 The launch FSM SHALL have exactly three states: IDLE, LAUNCH, BUSY.
REQ-021 IDLE -> LAUNCH when empty=0 and tx_busy=0. On that edge: pop the head entry, register it into tx_data, and set tx_start=1.
REQ-022 In LAUNCH, tx_start SHALL stay 1 and tx_data SHALL stay stable. On tx_busy=1: go to BUSY with tx_start=0 on the same edge.
REQ-023 In LAUNCH, if tx_busy has not risen after LAUNCH_TMO cycles: set launch_err, drop tx_start, and return to IDLE. The byte is discarded.
REQ-024 BUSY -> IDLE when tx_busy=0. No new launch SHALL occur in the cycle of that transition, which guarantees at least 1 idle cycle between frames.
REQ-025 tx_data SHALL hold its last launched value in all states until the next pop.
REQ-026 Latency: a write into an empty FIFO with FSM in IDLE and tx_busy=0 SHALL raise tx_start 2 cycles after the wr_en edge.
REQ-027 launch_err SHALL clear only on reset.

Reset
REQ-028 On reset=0, asynchronously: pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, launch_err=0, FSM=IDLE.
REQ-029 Reset asserted mid-frame SHALL discard all FIFO contents and drop tx_start immediately; the byte already transmitting is not tracked.
REQ-030 After reset deasserts, the first launch SHALL not occur before the first rising clk edge.

Structure
REQ-031 The FSM state encoding and the default widths (DATA=8, DEPTH=8) SHALL live in shared package uart_pkg.
REQ-032 FIFO storage and pointers SHALL be a sub-module sync_fifo (ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, count). The FSM stays in uart_tx_fifo_ctrl.

Verification
REQ-033 Write D3, A5, 3C, 55 back-to-back into uart_protocol -> rx_data sequence D3, A5, 3C, 55, 4 rx_valid pulses, parity_error=0 throughout.
REQ-034 Write 9 bytes in consecutive cycles while tx_busy is held 1 -> count=8, full=1, overflow pulses once on the 9th write, byte 9 is absent from the output.
REQ-035 With full=1 and a pop in progress, write 7E in the pop cycle -> accepted, count stays 8, 7E transmitted last.
REQ-036 Tie tx_busy=0 permanently and write 42 -> tx_start high for exactly 16 cycles, then launch_err=1, FSM=IDLE, count=0.
REQ-037 Assert reset=0 while tx_busy=1 with 3 bytes queued -> tx_start=0, count=0, empty=1 immediately; after release, no tx_start without new writes.
REQ-038 Write 8, drain 8, write 8 again -> pointer wrap; output order preserved across the wrap.
